// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard unit: forward-select encodings and the
// per-stage slot record tracked for in-flight destination registers.
package pipeline_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_EXMEM   = 2'b01,
    FWD_MEMWB   = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] dest;
    logic                      reg_write;
    logic                      mem_read;
  } slot_t;

  // Register 0 is hard-wired zero, so it never counts as produced.
  function automatic logic produces(input slot_t s, input logic [REG_ADDR_W_DEF-1:0] r);
    return s.valid & s.reg_write & (s.dest == r) & (r != '0);
  endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// Three-entry EX/MEM/WB slot shift register; EX takes the ID record or a bubble.
module hazard_slot_pipe
  import pipeline_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  slot_t id_slot_i,
  input  logic  load_i,
  output slot_t ex_o,
  output slot_t mem_o,
  output slot_t wb_o
);

  slot_t ex_q, mem_q, wb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= load_i ? id_slot_i : '0;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_o  = ex_q;
  assign mem_o = mem_q;
  assign wb_o  = wb_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard detection and forwarding control beside the ID stage of the 5-stage pipe.
// Outputs are combinational from the slots and ID inputs; counters update on the edge.
module pipeline_hazard_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_jump,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush_if_id,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  slot_t id_slot, ex_s, mem_s, wb_s;
  logic  ex_a, ex_b, mem_a, mem_b, use_a, use_b, hazard;
  fwd_sel_e fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  assign id_slot = '{valid: id_valid, dest: id_dest, reg_write: id_reg_write,
                     mem_read: id_mem_read};

  hazard_slot_pipe u_slots (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_slot_i (id_slot),
    .load_i    (id_valid & ~bubble),
    .ex_o      (ex_s),
    .mem_o     (mem_s),
    .wb_o      (wb_s)
  );

  // The WB slot is tracked but never consulted: the regfile is write-before-read.
  logic wb_unused;
  assign wb_unused = ^wb_s;

  assign ex_a  = produces(ex_s,  id_rs);
  assign ex_b  = produces(ex_s,  id_rt);
  assign mem_a = produces(mem_s, id_rs);
  assign mem_b = produces(mem_s, id_rt);
  assign use_a = id_valid & id_uses_rs;
  assign use_b = id_valid & id_uses_rt;

  always_comb begin
    fwd_a_d = FWD_REGFILE;
    fwd_b_d = FWD_REGFILE;
    hazard  = 1'b0;
    if (FWD_EN != 0) begin
      // Youngest producer wins.
      if (ex_a)       fwd_a_d = FWD_EXMEM;
      else if (mem_a) fwd_a_d = FWD_MEMWB;
      if (ex_b)       fwd_b_d = FWD_EXMEM;
      else if (mem_b) fwd_b_d = FWD_MEMWB;
      hazard = ex_s.mem_read & ((use_a & ex_a) | (use_b & ex_b));
    end else begin
      hazard = (use_a & (ex_a | mem_a)) | (use_b & (ex_b | mem_b));
    end
  end

  // A taken branch squashes the stalled ID instruction, so it overrides the stall.
  assign stall       = hazard & ~ex_branch_taken;
  assign bubble      = stall | ex_branch_taken;
  assign flush_if_id = ex_branch_taken | (id_jump & id_valid & ~stall);
  assign fwd_a_sel   = fwd_a_d;
  assign fwd_b_sel   = fwd_b_d;

  assign stall_cnt_d = (stall & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  assign flush_cnt_d = (flush_if_id & ~&flush_cnt_q) ? flush_cnt_q + 1'b1 : flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench: a forwarding instance and a no-forward instance share stimulus;
// narrow counters make saturation reachable.
module tb_pipeline_hazard_unit;
  localparam int AW = 5;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_jump;
  logic          ex_branch_taken;
  logic [AW-1:0] id_rs, id_rt, id_dest;

  logic          s1, b1, f1, s0, b0, f0;
  logic [1:0]    fa1, fb1, fa0, fb0;
  logic [CW-1:0] sc1, fc1, sc0, fc0;

  pipeline_hazard_unit #(.REG_ADDR_W(AW), .FWD_EN(1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
    .ex_branch_taken(ex_branch_taken), .stall(s1), .bubble(b1), .flush_if_id(f1),
    .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_cnt(sc1), .flush_cnt(fc1));

  pipeline_hazard_unit #(.REG_ADDR_W(AW), .FWD_EN(0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
    .ex_branch_taken(ex_branch_taken), .stall(s0), .bubble(b0), .flush_if_id(f0),
    .fwd_a_sel(fa0), .fwd_b_sel(fb0), .stall_cnt(sc0), .flush_cnt(fc0));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input int rs, input int rt, input logic urs,
                     input logic urt, input int dest, input logic rw, input logic mr);
    id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_dest = AW'(dest); id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic nop();
    put(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    id_jump = 1'b0;
  endtask

  task automatic rst();
    nop();
    ex_branch_taken = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    nop();
    ex_branch_taken = 1'b0;
    #2;
    chk("rst_stall", s1, 0);   chk("rst_bubble", b1, 0); chk("rst_flush", f1, 0);
    chk("rst_fwd_a", fa1, 0);  chk("rst_fwd_b", fb1, 0);
    chk("rst_scnt", sc1, 0);   chk("rst_fcnt", fc1, 0);  chk("rst_scnt0", sc0, 0);
    tick();
    rst_n = 1'b1;

    // add r3,r1,r2 ; sub r4,r3,r5
    rst();
    put(1, 1, 2, 1, 1, 3, 1, 0); tick();
    put(1, 3, 5, 1, 1, 4, 1, 0); #2;
    chk("exfwd_a", fa1, 2'b01); chk("exfwd_b", fb1, 2'b00); chk("exfwd_stall", s1, 0);

    // add r3 ; nop ; sub r4,r3,r5
    rst();
    put(1, 1, 2, 1, 1, 3, 1, 0); tick();
    nop(); tick();
    put(1, 3, 5, 1, 1, 4, 1, 0); #2;
    chk("memfwd_a", fa1, 2'b10); chk("memfwd_stall", s1, 0);

    // add r3 ; nop ; nop ; sub r4,r3,r3
    rst();
    put(1, 1, 2, 1, 1, 3, 1, 0); tick();
    nop(); tick(); nop(); tick();
    put(1, 3, 3, 1, 1, 4, 1, 0); #2;
    chk("wbfwd_a", fa1, 2'b00); chk("wbfwd_b", fb1, 2'b00);

    // add r3 ; add r3,r3,r1 ; sub r4,r3,r3 -> youngest producer
    rst();
    put(1, 1, 2, 1, 1, 3, 1, 0); tick();
    put(1, 3, 1, 1, 1, 3, 1, 0); #2;
    chk("young1_a", fa1, 2'b01); tick();
    put(1, 3, 3, 1, 1, 4, 1, 0); #2;
    chk("young2_a", fa1, 2'b01); chk("young2_b", fb1, 2'b01);

    // lw r2,0(r1) ; add r4,r2,r2
    rst();
    put(1, 1, 0, 1, 0, 2, 1, 1); tick();
    put(1, 2, 2, 1, 1, 4, 1, 0); #2;
    chk("lu_stall", s1, 1); chk("lu_bubble", b1, 1); chk("lu_flush", f1, 0);
    tick(); #1;
    chk("lu2_stall", s1, 0); chk("lu2_bubble", b1, 0);
    chk("lu2_fwd_a", fa1, 2'b10); chk("lu2_fwd_b", fb1, 2'b10); chk("lu2_scnt", sc1, 1);
    tick(); nop(); #2;
    chk("lu3_scnt", sc1, 1);

    // add r0,r1,r2 ; sub r5,r0,r0, then lw r0 ; use r0
    rst();
    put(1, 1, 2, 1, 1, 0, 1, 0); tick();
    put(1, 0, 0, 1, 1, 5, 1, 0); #2;
    chk("r0_fwd_a", fa1, 0); chk("r0_fwd_b", fb1, 0); chk("r0_stall", s1, 0);
    chk("r0_stall_nofwd", s0, 0);
    tick();
    put(1, 1, 0, 1, 0, 0, 1, 1); tick();
    put(1, 0, 0, 1, 1, 4, 1, 0); #2;
    chk("r0_lu_stall", s1, 0);

    // branch taken while a load-use stall is pending
    rst();
    put(1, 1, 0, 1, 0, 2, 1, 1); tick();
    put(1, 2, 2, 1, 1, 4, 1, 0); ex_branch_taken = 1'b1; #2;
    chk("br_stall", s1, 0); chk("br_bubble", b1, 1); chk("br_flush", f1, 1);
    tick(); ex_branch_taken = 1'b0; nop(); #2;
    chk("br_fcnt", fc1, 1); chk("br_scnt", sc1, 0);

    // jump decoded while stalled: flush deferred one cycle
    rst();
    put(1, 1, 0, 1, 0, 2, 1, 1); tick();
    put(1, 2, 2, 1, 1, 4, 1, 0); id_jump = 1'b1; #2;
    chk("jmp_stall", s1, 1); chk("jmp_flush_held", f1, 0);
    tick(); #1;
    chk("jmp2_stall", s1, 0); chk("jmp2_flush", f1, 1);
    tick(); nop(); #2;
    chk("jmp_fcnt", fc1, 1); chk("jmp_scnt", sc1, 1);

    // FWD_EN=0: add r3 ; sub r4,r3,r5 -> two stall cycles
    rst();
    put(1, 1, 2, 1, 1, 3, 1, 0); tick();
    put(1, 3, 5, 1, 1, 4, 1, 0); #2;
    chk("nf1_stall", s0, 1); chk("nf1_fwd_a", fa0, 0); chk("nf1_fwd_stall1", s1, 0);
    tick(); #1;
    chk("nf2_stall", s0, 1); chk("nf2_bubble", b0, 1); chk("nf2_fwd_a", fa0, 0);
    tick(); #1;
    chk("nf3_stall", s0, 0); chk("nf3_fwd_a", fa0, 0);
    tick(); nop(); #2;
    chk("nf_scnt", sc0, 2);

    // async reset in the middle of a stall
    rst();
    put(1, 1, 0, 1, 0, 2, 1, 1); tick();
    put(1, 2, 2, 1, 1, 4, 1, 0); #2;
    chk("mid_pre_stall", s1, 1);
    rst_n = 1'b0; #1;
    chk("mid_stall", s1, 0); chk("mid_bubble", b1, 0); chk("mid_flush", f1, 0);
    chk("mid_fwd_a", fa1, 0); chk("mid_fwd_b", fb1, 0); chk("mid_stall0", s0, 0);
    tick(); rst_n = 1'b1;

    // stall counter saturation on the no-forward instance (8 stalls into 3 bits)
    rst();
    for (int i = 0; i < 4; i++) begin
      put(1, 1, 2, 1, 1, 3, 1, 0); tick();
      put(1, 3, 5, 1, 1, 4, 1, 0); tick(); tick(); tick();
    end
    nop(); #2;
    chk("sat_scnt", sc0, 7);

    // flush counter saturation
    rst();
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("sat_fcnt6", fc1, 6);
    for (int i = 0; i < 3; i++) tick();
    ex_branch_taken = 1'b0; #2;
    chk("sat_fcnt", fc1, 7); chk("sat_flush_off", f1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
